ct_trace_checker: RTL and testbench

Downstream consumer of the two-copy out-of-order observation stream used in constant-time checking. Each cycle, each copy may emit one observation record: commit count plus data-memory address. The block buffers each copy's records in its own FIFO and compares them pairwise in program order, so bounded timing skew between the copies is tolerated. It raises a sticky violation on the first record mismatch or on skew overflow. It sits between the two topsim instances and the property layer, which asserts on its `violation` output instead of comparing raw signals in lockstep.

---
 rtl/ct_obs_if.sv | 22 ++
 rtl/ct_trace_checker.sv | 123 ++++++++++++
 tb/tb_ct_trace_checker.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/ct_obs_if.sv
// Observation stream from the two topsim copies into the trace checker.
// Each copy presents at most one {cnum, addr} record per cycle.
interface ct_obs_if #(
  parameter int ADDR_W = 32
);
  logic              obs1_valid;
  logic [1:0]        obs1_cnum;
  logic [ADDR_W-1:0] obs1_addr;
  logic              obs2_valid;
  logic [1:0]        obs2_cnum;
  logic [ADDR_W-1:0] obs2_addr;

  modport master (
    output obs1_valid, obs1_cnum, obs1_addr,
    output obs2_valid, obs2_cnum, obs2_addr
  );

  modport slave (
    input obs1_valid, obs1_cnum, obs1_addr,
    input obs2_valid, obs2_cnum, obs2_addr
  );
endinterface

// File: rtl/ct_trace_checker.sv
// Buffers the two copies' observation records in per-copy FIFOs and compares
// them pairwise in program order; raises a sticky violation on mismatch or overflow.
module ct_trace_checker #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       reset_x,
  input  logic                       enable,
  ct_obs_if.slave                    obs,
  output logic                       violation,
  output logic [1:0]                 fail_cause,
  output logic [CNT_W-1:0]           fail_index,
  output logic [CNT_W-1:0]           cmp_count,
  output logic [$clog2(DEPTH)+1:0]   skew
);
  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = AW + 1;
  localparam int SW    = AW + 2;
  localparam int REC_W = ADDR_W + 2;
  localparam logic [PW-1:0]    PTR_ONE = PW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {RUN, FAIL} state_t;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISMATCH = 2'b01;
  localparam logic [1:0] CAUSE_OVF1     = 2'b10;
  localparam logic [1:0] CAUSE_OVF2     = 2'b11;

  state_t            state, state_next;
  logic [REC_W-1:0]  mem1 [DEPTH];
  logic [REC_W-1:0]  mem2 [DEPTH];
  logic [PW-1:0]     wr1, rd1, wr2, rd2;
  logic [PW-1:0]     occ1, occ2;
  logic [REC_W-1:0]  rec1, rec2, head1, head2;
  logic              empty1, empty2, full1, full2;
  logic              req1, req2, push1, push2, pop;
  logic              mismatch, ovf1, ovf2;
  logic [1:0]        cause_next;

  assign rec1   = {obs.obs1_cnum, obs.obs1_addr};
  assign rec2   = {obs.obs2_cnum, obs.obs2_addr};
  assign head1  = mem1[rd1[AW-1:0]];
  assign head2  = mem2[rd2[AW-1:0]];
  assign empty1 = (wr1 == rd1);
  assign empty2 = (wr2 == rd2);
  assign full1  = (wr1[AW-1:0] == rd1[AW-1:0]) && (wr1[PW-1] != rd1[PW-1]);
  assign full2  = (wr2[AW-1:0] == rd2[AW-1:0]) && (wr2[PW-1] != rd2[PW-1]);
  assign req1   = obs.obs1_valid && enable;
  assign req2   = obs.obs2_valid && enable;

  assign occ1      = wr1 - rd1;
  assign occ2      = wr2 - rd2;
  assign skew      = SW'({1'b0, occ1}) - SW'({1'b0, occ2});
  assign violation = (state == FAIL);

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    cause_next = fail_cause;
    pop        = 1'b0;
    mismatch   = 1'b0;
    ovf1       = 1'b0;
    ovf2       = 1'b0;
    push1      = 1'b0;
    push2      = 1'b0;
    if (state == RUN) begin
      pop      = !empty1 && !empty2;
      mismatch = pop && (head1 != head2);
      // A pop frees a slot on the same edge, so a push into a full FIFO is legal then.
      ovf1     = req1 && full1 && !pop;
      ovf2     = req2 && full2 && !pop;
      push1    = req1 && !ovf1;
      push2    = req2 && !ovf2;
      if (mismatch) begin
        state_next = FAIL;
        cause_next = CAUSE_MISMATCH;
      end else if (ovf1) begin
        state_next = FAIL;
        cause_next = CAUSE_OVF1;
      end else if (ovf2) begin
        state_next = FAIL;
        cause_next = CAUSE_OVF2;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_x) begin
      state      <= RUN;
      wr1        <= '0;
      rd1        <= '0;
      wr2        <= '0;
      rd2        <= '0;
      cmp_count  <= '0;
      fail_cause <= CAUSE_NONE;
      fail_index <= '0;
    end else begin
      state <= state_next;
      if (push1) wr1 <= wr1 + PTR_ONE;
      if (push2) wr2 <= wr2 + PTR_ONE;
      if (pop) begin
        rd1 <= rd1 + PTR_ONE;
        rd2 <= rd2 + PTR_ONE;
      end
      if (pop && !mismatch && cmp_count != CNT_MAX) cmp_count <= cmp_count + CNT_ONE;
      if (state == RUN && state_next == FAIL) begin
        fail_cause <= cause_next;
        fail_index <= cmp_count;
      end
    end
  end

  // NOTE: record storage is not reset; the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push1) mem1[wr1[AW-1:0]] <= rec1;
    if (push2) mem2[wr2[AW-1:0]] <= rec2;
  end
endmodule

// File: tb/tb_ct_trace_checker.sv
// Directed bench for ct_trace_checker: a queue-based reference model checked every
// cycle, plus literal expectations for each scenario.
module tb_ct_trace_checker;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 16;

  logic clk = 1'b0;
  logic reset_x = 1'b0;
  logic enable = 1'b1;
  logic violation;
  logic [1:0] fail_cause;
  logic [CNT_W-1:0] fail_index, cmp_count;
  logic [$clog2(DEPTH)+1:0] skew;

  ct_obs_if #(.ADDR_W(ADDR_W)) obs ();

  ct_trace_checker #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_x(reset_x), .enable(enable), .obs(obs),
    .violation(violation), .fail_cause(fail_cause), .fail_index(fail_index),
    .cmp_count(cmp_count), .skew(skew)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit started = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-copy queues of {cnum, addr}, updated from pre-edge inputs.
  logic [ADDR_W+1:0] q1[$];
  logic [ADDR_W+1:0] q2[$];
  bit m_failed = 0;
  int m_cause = 0, m_index = 0, m_count = 0;

  always @(posedge clk) begin
    if (!reset_x) begin
      q1.delete(); q2.delete();
      m_failed = 0; m_cause = 0; m_index = 0; m_count = 0;
    end else if (!m_failed) begin
      bit both, mism, want1, want2, ov1, ov2;
      both  = (q1.size() > 0) && (q2.size() > 0);
      mism  = both && (q1[0] != q2[0]);
      want1 = obs.obs1_valid && enable;
      want2 = obs.obs2_valid && enable;
      ov1   = want1 && q1.size() == DEPTH && !both;
      ov2   = want2 && q2.size() == DEPTH && !both;
      if (mism) begin
        m_failed = 1; m_cause = 1; m_index = m_count;
      end else if (ov1) begin
        m_failed = 1; m_cause = 2; m_index = m_count;
      end else if (ov2) begin
        m_failed = 1; m_cause = 3; m_index = m_count;
      end
      if (both) begin
        void'(q1.pop_front()); void'(q2.pop_front());
        if (!mism && m_count < 65535) m_count++;
      end
      if (want1 && !ov1) q1.push_back({obs.obs1_cnum, obs.obs1_addr});
      if (want2 && !ov2) q2.push_back({obs.obs2_cnum, obs.obs2_addr});
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("violation", violation, m_failed);
      check("fail_cause", fail_cause, m_cause);
      check("fail_index", fail_index, m_index);
      check("cmp_count", cmp_count, m_count);
      if (!m_failed) check("skew", $signed(skew), q1.size() - q2.size());
    end
  end

  task automatic step(input logic v1, input logic [1:0] c1, input logic [31:0] a1,
                      input logic v2, input logic [1:0] c2, input logic [31:0] a2);
    obs.obs1_valid = v1; obs.obs1_cnum = c1; obs.obs1_addr = a1;
    obs.obs2_valid = v2; obs.obs2_cnum = c2; obs.obs2_addr = a2;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 2'd0, 32'h0, 0, 2'd0, 32'h0);
  endtask

  task automatic do_reset();
    reset_x = 1'b0;
    idle(1);
    reset_x = 1'b1;
  endtask

  initial begin
    obs.obs1_valid = 0; obs.obs1_cnum = 0; obs.obs1_addr = 0;
    obs.obs2_valid = 0; obs.obs2_cnum = 0; obs.obs2_addr = 0;
    do_reset();
    started = 1;
    check("rst_violation", violation, 0);
    check("rst_count", cmp_count, 0);
    check("rst_skew", skew, 0);

    // Lockstep equal records
    step(1, 2'd1, 32'h100, 1, 2'd1, 32'h100);
    step(1, 2'd2, 32'h104, 1, 2'd2, 32'h104);
    step(1, 2'd0, 32'h0,   1, 2'd0, 32'h0);
    check("lock_skew", skew, 0);
    idle(1);
    check("lock_count", cmp_count, 3);
    check("lock_viol", violation, 0);
    idle(2);

    // Skewed equal records: copy 2 lags by five cycles
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 2'(i), 32'h200 + 32'(4 * i), 0, 2'd0, 32'h0);
    idle(1);
    check("skew_peak", skew, 4);
    for (int i = 0; i < 4; i++) step(0, 2'd0, 32'h0, 1, 2'(i), 32'h200 + 32'(4 * i));
    idle(2);
    check("skew_count", cmp_count, 4);
    check("skew_final", skew, 0);
    check("skew_viol", violation, 0);

    // Mismatch on the third pair
    do_reset();
    step(1, 2'd1, 32'h10, 1, 2'd1, 32'h10);
    step(1, 2'd2, 32'h14, 1, 2'd2, 32'h14);
    step(1, 2'd1, 32'h200, 1, 2'd1, 32'h204);
    check("mis_early", violation, 0);
    idle(1);
    check("mis_viol", violation, 1);
    check("mis_cause", fail_cause, 1);
    check("mis_index", fail_index, 2);
    check("mis_count", cmp_count, 2);
    step(1, 2'd3, 32'h40, 1, 2'd3, 32'h40);
    step(1, 2'd3, 32'h44, 1, 2'd3, 32'h44);
    idle(2);
    check("mis_frozen", cmp_count, 2);
    check("mis_sticky", violation, 1);

    // Reset recovery, then one equal pair
    do_reset();
    check("rec_viol", violation, 0);
    check("rec_cause", fail_cause, 0);
    check("rec_index", fail_index, 0);
    check("rec_count", cmp_count, 0);
    check("rec_skew", skew, 0);
    step(1, 2'd2, 32'h300, 1, 2'd2, 32'h300);
    idle(1);
    check("rec_pair", cmp_count, 1);

    // Pushes ignored while enable is low
    enable = 1'b0;
    for (int i = 0; i < 3; i++) step(1, 2'd1, 32'h400, 1, 2'd1, 32'h404);
    enable = 1'b1;
    idle(2);
    check("en_count", cmp_count, 1);
    check("en_skew", skew, 0);
    check("en_viol", violation, 0);

    // Copy-1 overflow on the ninth push
    do_reset();
    for (int i = 0; i < 8; i++) step(1, 2'(i), 32'h1000 + 32'(4 * i), 0, 2'd0, 32'h0);
    check("ovf_full_skew", skew, 8);
    check("ovf_full_viol", violation, 0);
    step(1, 2'd0, 32'h1020, 0, 2'd0, 32'h0);
    check("ovf_viol", violation, 1);
    check("ovf_cause", fail_cause, 2);
    check("ovf_index", fail_index, 0);
    idle(1);

    // Full FIFO with same-edge pop and push is legal
    do_reset();
    for (int i = 0; i < 8; i++) step(1, 2'(i), 32'h1000 + 32'(4 * i), 0, 2'd0, 32'h0);
    step(0, 2'd0, 32'h0, 1, 2'd0, 32'h1000);
    step(1, 2'd0, 32'h1020, 0, 2'd0, 32'h0);
    check("popush_viol", violation, 0);
    check("popush_count", cmp_count, 1);
    check("popush_skew", skew, 8);
    idle(2);

    // Copy-2 overflow
    do_reset();
    for (int i = 0; i < 9; i++) step(0, 2'd0, 32'h0, 1, 2'(i), 32'h2000 + 32'(4 * i));
    check("ovf2_cause", fail_cause, 3);
    check("ovf2_viol", violation, 1);
    idle(1);

    started = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
